// File: rtl/des_round_sched.sv
// -----------------------------------------------------------------------------
// des_round_sched
//
// Round scheduler for the DES key schedule. A 64-bit key and an
// encrypt/decrypt mode are accepted through a valid/ready handshake. The block
// then drives the round index into the combinational key-schedule block for 16
// rounds: ascending when encrypting, descending when decrypting. Each returned
// 48-bit subkey is registered, tagged with its Feistel round number (1..16) and
// presented to the round datapath. Completion is reported through an output
// valid/ready handshake.
//
// Ports
//   i_clk           clock, all state updates on the rising edge
//   i_rst           synchronous active-high reset
//   i_in_valid      request valid
//   o_in_ready      request accepted when i_in_valid & o_in_ready (IDLE only)
//   i_in_key        64-bit DES key (with parity bits), sampled on accept
//   i_in_decrypt    0 = encrypt, 1 = decrypt, sampled on accept
//   o_ks_key        latched key driven to the key-schedule block
//   o_ks_cnt        round index driven to the key-schedule block (0 when idle)
//   i_ks_round_key  subkey returned combinationally for o_ks_cnt
//   i_stall         datapath backpressure, freezes sequencing in RUN/DRAIN
//   o_rk            registered subkey
//   o_rk_valid      o_rk valid this cycle
//   o_rk_round      Feistel round number that o_rk belongs to
//   o_rk_last       high with o_rk_valid for round 16
//   o_busy          any state other than IDLE
//   o_out_valid     operation complete
//   i_out_ready     completion acknowledged when o_out_valid & i_out_ready
//   i_abort         synchronous cancel, highest priority after reset
// -----------------------------------------------------------------------------
module des_round_sched (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [63:0] i_in_key,
  input  logic        i_in_decrypt,
  output logic [63:0] o_ks_key,
  output logic [4:0]  o_ks_cnt,
  input  logic [47:0] i_ks_round_key,
  input  logic        i_stall,
  output logic [47:0] o_rk,
  output logic        o_rk_valid,
  output logic [4:0]  o_rk_round,
  output logic        o_rk_last,
  output logic        o_busy,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  input  logic        i_abort
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [63:0] r_key;
  logic        r_mode;
  logic [4:0]  r_cnt;
  logic [47:0] r_rk;
  logic        r_rk_valid;
  logic [4:0]  r_rk_round;
  logic        r_rk_last;
  logic [4:0]  w_ks_cnt;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; abort overrides every other condition.
  always_comb begin
    w_state_nxt = r_state;
    if (i_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_RUN: begin
          if (i_stall) begin
            w_state_nxt = S_RUN;
          end else if (r_cnt == 5'd16) begin
            w_state_nxt = S_DRAIN;
          end else begin
            w_state_nxt = S_RUN;
          end
        end
        S_DRAIN: begin
          if (i_stall) begin
            w_state_nxt = S_DRAIN;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
        S_DONE: begin
          // Backpressure from the datapath has no meaning once all subkeys
          // have been delivered, so only the completion handshake matters.
          if (i_out_ready) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Key/mode capture, round counter and registered subkey output.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_key      <= 64'd0;
      r_mode     <= 1'b0;
      r_cnt      <= 5'd1;
      r_rk       <= 48'd0;
      r_rk_valid <= 1'b0;
      r_rk_round <= 5'd0;
      r_rk_last  <= 1'b0;
    end else if (i_abort) begin
      // The key stays latched; a request offered alongside abort is dropped.
      r_cnt      <= 5'd1;
      r_rk_valid <= 1'b0;
      r_rk_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_key  <= i_in_key;
            r_mode <= i_in_decrypt;
            r_cnt  <= 5'd1;
          end
        end
        S_RUN: begin
          if (!i_stall) begin
            r_rk       <= i_ks_round_key;
            r_rk_round <= r_cnt;
            r_rk_valid <= 1'b1;
            r_rk_last  <= (r_cnt == 5'd16);
            // Counter parks at 16 on the final round; accept reloads it.
            if (r_cnt != 5'd16) begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
        end
        S_DRAIN: begin
          if (!i_stall) begin
            r_rk_valid <= 1'b0;
            r_rk_last  <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Round index for the key schedule: mirrored for decryption, 0 outside RUN.
  always_comb begin
    w_ks_cnt = 5'd0;
    if (r_state == S_RUN) begin
      if (r_mode) begin
        w_ks_cnt = 5'd17 - r_cnt;
      end else begin
        w_ks_cnt = r_cnt;
      end
    end else begin
      w_ks_cnt = 5'd0;
    end
  end

  assign o_in_ready  = (r_state == S_IDLE);
  assign o_busy      = (r_state != S_IDLE);
  assign o_out_valid = (r_state == S_DONE);
  assign o_ks_key    = r_key;
  assign o_ks_cnt    = w_ks_cnt;
  assign o_rk        = r_rk;
  assign o_rk_valid  = r_rk_valid;
  assign o_rk_round  = r_rk_round;
  assign o_rk_last   = r_rk_last;

endmodule
